// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, stop
// tx is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx_frame #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  tx_arst_n,
  input  logic                  tx_rst,
  input  logic                  tx_en,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [DATA_WIDTH-1:0]   shreg, shreg_n;
  logic                    par, par_n;
  logic                    tx_n, busy_n, done_n;
  logic                    bit_end;

  assign bit_end = (cnt == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (tx_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    tx_n    = 1'b1;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_n = tx_data;
          par_n   = (^tx_data) ^ (PARITY_ODD != 0);
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            idx_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        tx_n = par;
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    // Disable aborts the frame outright; it is never resumed.
    if (!tx_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      tx_n    = 1'b1;
      done_n  = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
// Three instances (even parity, odd parity, no parity) share inputs; tx_start is steered by sel.
module tb_uart_tx_frame;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       tx_arst_n = 1'b0;
  logic       tx_rst = 1'b0;
  logic       tx_en = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  int         sel = 0;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;
  logic tx_m, busy_m, done_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.BAUD_DIV(B), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_en(tx_en),
    .tx_start(tx_start && sel == 0), .tx_data(tx_data),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_frame #(.BAUD_DIV(B), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_en(tx_en),
    .tx_start(tx_start && sel == 1), .tx_data(tx_data),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

  uart_tx_frame #(.BAUD_DIV(B), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
    .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_en(tx_en),
    .tx_start(tx_start && sel == 2), .tx_data(tx_data),
    .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

  assign tx_m   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
  assign busy_m = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign done_m = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

  typedef struct {
    int          s;
    logic [7:0]  d;
    logic [15:0] seq;
    int          nb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic etx, input logic ebusy, input logic edone);
    @(negedge clk);
    chk({nm, ".tx"}, tx_m, etx);
    chk({nm, ".busy"}, busy_m, ebusy);
    chk({nm, ".done"}, done_m, edone);
  endtask

  task automatic idle(input string nm, input int n);
    for (int k = 0; k < n; k++) step(nm, 1'b1, 1'b0, 1'b0);
  endtask

  // Reference: line bits in transmit order, parity from a count of ones.
  function automatic void model(input int s, input logic [7:0] d,
                                output logic [15:0] seq, output int nb);
    int ones;
    ones = 0;
    seq  = '0;
    nb   = 0;
    seq[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      seq[nb] = d[i];
      if (d[i]) ones++;
      nb++;
    end
    if (s != 2) begin
      seq[nb] = (s == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      nb++;
    end
    seq[nb] = 1'b1; nb++;
  endfunction

  // Cycle 0 drives the request; cycle c (1-based) is sampled after the c-th edge.
  task automatic frame(input string nm, input int s, input logic [7:0] d,
                       input logic [15:0] seq, input int nb, input bit noise,
                       input bit chain_in, input bit chain_out,
                       input logic [7:0] nd, input int stop_at);
    int   len;
    logic etx;
    len = nb * B;
    if (!chain_in) begin
      sel      = s;
      tx_data  = d;
      tx_start = 1'b1;
    end
    for (int c = 1; c <= len + 1; c++) begin
      etx = (c == 1) ? 1'b1 : seq[(c - 2) / B];
      step($sformatf("%s.c%0d", nm, c), etx, c <= len, c == len + 1);
      if (c == len + 1) begin
        tx_start = chain_out;
        tx_data  = nd;
      end else if (noise) begin
        tx_start = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end else if (!chain_out) begin
        tx_start = 1'b0;
      end
      if (c == stop_at) return;
    end
  endtask

  initial begin
    logic [15:0] seq, seq2;
    int          nb, nb2, s;
    logic [7:0]  d;
    bit          noise;

    vecs[0] = '{0, 8'hA5, 16'h054A, 11};
    vecs[1] = '{1, 8'h00, 16'h0600, 11};
    vecs[2] = '{2, 8'hFF, 16'h03FE, 10};
    vecs[3] = '{0, 8'h3C, 16'h0478, 11};
    vecs[4] = '{1, 8'hA5, 16'h074A, 11};

    // Reset state on every instance
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk($sformatf("reset%0d.tx", i), tx_m, 1'b1);
      chk($sformatf("reset%0d.busy", i), busy_m, 1'b0);
      chk($sformatf("reset%0d.done", i), done_m, 1'b0);
    end
    @(negedge clk);
    tx_arst_n = 1'b1;
    sel = 0;
    idle("post_reset", 2);

    // Table vectors with bench-written expected line sequences
    for (int i = 0; i < 5; i++) begin
      frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].seq, vecs[i].nb,
            1'b0, 1'b0, 1'b0, 8'h00, 0);
      idle($sformatf("vec%0d.after", i), 3);
    end

    // Back-to-back with tx_start held high
    model(0, 8'h55, seq, nb);
    model(0, 8'h0F, seq2, nb2);
    frame("b2b1", 0, 8'h55, seq, nb, 1'b0, 1'b0, 1'b1, 8'h0F, 0);
    frame("b2b2", 0, 8'h0F, seq2, nb2, 1'b0, 1'b1, 1'b0, 8'h00, 0);
    idle("b2b.after", 4);

    // Start pulses and data churn during a frame
    model(1, 8'h96, seq, nb);
    frame("noise", 1, 8'h96, seq, nb, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    idle("noise.after", 6);

    // tx_en dropped during data bit 3
    model(0, 8'hC3, seq, nb);
    frame("abort", 0, 8'hC3, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 18);
    tx_en = 1'b0;
    step("abort.drop", 1'b1, 1'b0, 1'b0);
    tx_start = 1'b1;
    idle("abort.en_low", 3);
    tx_start = 1'b0;
    tx_en = 1'b1;
    idle("abort.reen", 1);
    frame("abort.fresh", 0, 8'hC3, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    idle("abort.after", 2);

    // Sync reset mid-data
    model(2, 8'h6B, seq, nb);
    frame("srst", 2, 8'h6B, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 10);
    tx_rst = 1'b1;
    step("srst.hit", 1'b1, 1'b0, 1'b0);
    tx_rst = 1'b0;
    idle("srst.rel", 2);
    frame("srst.fresh", 2, 8'h6B, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    idle("srst.after", 2);

    // Async reset mid-stop-bit
    model(1, 8'h3A, seq, nb);
    frame("arst", 1, 8'h3A, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 42);
    tx_arst_n = 1'b0;
    #1;
    chk("arst.hit.tx", tx_m, 1'b1);
    chk("arst.hit.busy", busy_m, 1'b0);
    chk("arst.hit.done", done_m, 1'b0);
    @(negedge clk);
    tx_arst_n = 1'b1;
    idle("arst.rel", 2);
    frame("arst.fresh", 1, 8'h3A, seq, nb, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    idle("arst.after", 2);

    // Randomized frames against the reference model
    for (int r = 0; r < 8; r++) begin
      s     = $urandom_range(0, 2);
      d     = 8'($urandom);
      noise = 1'($urandom_range(0, 1));
      model(s, d, seq, nb);
      frame($sformatf("rnd%0d", r), s, d, seq, nb, noise, 1'b0, 1'b0, 8'h00, 0);
      idle($sformatf("rnd%0d.after", r), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
